// File: rtl/ball_pkg.sv
// ---------------------------------------------------------------------------
// ball_pkg
// Shared definitions for the ball game frame-buffer path:
//   - screen geometry (SCR_WIDTH x SCR_HEIGHT)
//   - coordinate and colour widths
//   - 3-bit RGB colour constants
//   - rect_fill_gen state encoding
// ---------------------------------------------------------------------------
package ball_pkg;

    localparam int SCR_WIDTH  = 240;
    localparam int SCR_HEIGHT = 320;

    localparam int COORD_XW = 8;
    localparam int COORD_YW = 9;
    localparam int COLOR_W  = 3;

    localparam logic [COLOR_W-1:0] BLACK   = 3'b000;
    localparam logic [COLOR_W-1:0] BLUE    = 3'b001;
    localparam logic [COLOR_W-1:0] GREEN   = 3'b010;
    localparam logic [COLOR_W-1:0] CYAN    = 3'b011;
    localparam logic [COLOR_W-1:0] RED     = 3'b100;
    localparam logic [COLOR_W-1:0] MAGENTA = 3'b101;
    localparam logic [COLOR_W-1:0] YELLOW  = 3'b110;
    localparam logic [COLOR_W-1:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } rfg_state_t;

endpackage

// File: rtl/rect_clip.sv
// ---------------------------------------------------------------------------
// rect_clip
// Combinational clipping of a rectangle command against the screen.
//   x0, y0 : rectangle origin (left column, top row)
//   w, h   : rectangle size in pixels
//   xe, ye : last column / row actually on screen, min(origin+size-1, edge)
//   empty  : nothing to draw (zero size or origin off screen)
// xe/ye are meaningless when empty is set.
// ---------------------------------------------------------------------------
module rect_clip
    import ball_pkg::*;
#(
    parameter int WIDTH  = SCR_WIDTH,
    parameter int HEIGHT = SCR_HEIGHT,
    parameter int XW     = COORD_XW,
    parameter int YW     = COORD_YW
) (
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    output logic [XW-1:0] xe,
    output logic [YW-1:0] ye,
    output logic          empty
);

    localparam logic [XW:0] X_MAX = (XW+1)'(WIDTH - 1);
    localparam logic [YW:0] Y_MAX = (YW+1)'(HEIGHT - 1);
    localparam logic [XW:0] X_LIM = (XW+1)'(WIDTH);
    localparam logic [YW:0] Y_LIM = (YW+1)'(HEIGHT);

    // One extra bit so origin+size-1 never wraps.
    logic [XW:0] x_sum;
    logic [YW:0] y_sum;

    assign x_sum = {1'b0, x0} + {1'b0, w} - (XW+1)'(1);
    assign y_sum = {1'b0, y0} + {1'b0, h} - (YW+1)'(1);

    always_comb begin
        xe = (x_sum > X_MAX) ? X_MAX[XW-1:0] : x_sum[XW-1:0];
        ye = (y_sum > Y_MAX) ? Y_MAX[YW-1:0] : y_sum[YW-1:0];
        empty = (w == '0) || (h == '0) ||
                ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
    end

endmodule

// File: rtl/rect_fill_gen.sv
// ---------------------------------------------------------------------------
// rect_fill_gen
// Turns one rectangle command into a raster stream of pixel writes
// (x fastest, then y), clipped to the screen, with a ready handshake.
//
// Ports:
//   clk50M      system clock
//   rst         synchronous active-high reset
//   start       command strobe, only looked at while idle
//   x0, y0      rectangle origin
//   w, h        rectangle size
//   fill_color  colour of every emitted pixel
//   outline     (RECT_OUTLINE_EN builds only) emit perimeter only
//   pixel_ready downstream takes the current pixel this cycle
//   busy        pixels are being emitted
//   done        one-cycle pulse when the command completes
//   x, y        pixel coordinate
//   write_en    pixel valid
//   color       pixel colour
//
// Build option: define RECT_OUTLINE_EN to add the outline input.
// ---------------------------------------------------------------------------
module rect_fill_gen
    import ball_pkg::*;
#(
    parameter int WIDTH  = SCR_WIDTH,
    parameter int HEIGHT = SCR_HEIGHT,
    parameter int XW     = COORD_XW,
    parameter int YW     = COORD_YW,
    parameter int CW     = COLOR_W
) (
    input  logic          clk50M,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] fill_color,
`ifdef RECT_OUTLINE_EN
    input  logic          outline,
`endif
    input  logic          pixel_ready,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          write_en,
    output logic [CW-1:0] color
);

    rfg_state_t state, state_nxt;

    logic [XW-1:0] clip_xe;
    logic [YW-1:0] clip_ye;
    logic          clip_empty;

    logic [XW-1:0] xs_r;
    logic [XW-1:0] xe_r;
    logic [YW-1:0] ys_r;
    logic [YW-1:0] ye_r;
    logic          outline_r;
    logic          outline_in;
    logic          last_pix;

`ifdef RECT_OUTLINE_EN
    assign outline_in = outline;
`else
    assign outline_in = 1'b0;
`endif

    rect_clip #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .XW    (XW),
        .YW    (YW)
    ) u_clip (
        .x0   (x0),
        .y0   (y0),
        .w    (w),
        .h    (h),
        .xe   (clip_xe),
        .ye   (clip_ye),
        .empty(clip_empty)
    );

    assign last_pix = (x == xe_r) && (y == ye_r);

    // State register
    always_ff @(posedge clk50M) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = clip_empty ? FIN : DRAW;
                end
            end
            DRAW: begin
                if (pixel_ready && last_pix) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; all terms come straight from the state register.
    always_comb begin
        busy     = (state == DRAW);
        write_en = (state == DRAW);
        done     = (state == FIN);
    end

    // Command capture and raster walk.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            color     <= '0;
            xs_r      <= '0;
            xe_r      <= '0;
            ys_r      <= '0;
            ye_r      <= '0;
            outline_r <= 1'b0;
        end else if (state == IDLE && start) begin
            x         <= x0;
            y         <= y0;
            color     <= fill_color;
            xs_r      <= x0;
            xe_r      <= clip_xe;
            ys_r      <= y0;
            ye_r      <= clip_ye;
            outline_r <= outline_in;
        end else if (state == DRAW && pixel_ready && !last_pix) begin
            if (x == xe_r) begin
                x <= xs_r;
                y <= y + 1'b1;
            end else if (outline_r && y != ys_r && y != ye_r) begin
                // Interior outline rows: left edge jumps straight to right edge.
                x <= xe_r;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rect_fill_gen.sv
// ---------------------------------------------------------------------------
// tb_rect_fill_gen
// Self-checking bench for rect_fill_gen against a list-of-pixels model.
// Define RECT_OUTLINE_EN for both bench and RTL to cover the outline mode.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rect_fill_gen;

    localparam int WIDTH  = 240;
    localparam int HEIGHT = 320;

    logic       clk50M = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x0 = '0;
    logic [8:0] y0 = '0;
    logic [7:0] w = '0;
    logic [8:0] h = '0;
    logic [2:0] fill_color = '0;
    logic       pixel_ready = 1'b0;
    logic       busy, done, write_en;
    logic [7:0] x;
    logic [8:0] y;
    logic [2:0] color;
`ifdef RECT_OUTLINE_EN
    logic       outline = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk50M = ~clk50M;

    rect_fill_gen #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .XW    (8),
        .YW    (9),
        .CW    (3)
    ) dut (
        .clk50M     (clk50M),
        .rst        (rst),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .fill_color (fill_color),
`ifdef RECT_OUTLINE_EN
        .outline    (outline),
`endif
        .pixel_ready(pixel_ready),
        .busy       (busy),
        .done       (done),
        .x          (x),
        .y          (y),
        .write_en   (write_en),
        .color      (color)
    );

    task automatic scramble_cmd();
        x0         = 8'($urandom);
        y0         = 9'($urandom);
        w          = 8'($urandom);
        h          = 9'($urandom);
        fill_color = 3'($urandom);
`ifdef RECT_OUTLINE_EN
        outline    = 1'($urandom);
`endif
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || write_en !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: busy=%b done=%b write_en=%b required 0/0/0",
                     name, busy, done, write_en);
        end
    endtask

    // rmode: 0 ready always, 1 ready on alternate cycles, 2 random ready
    // noise: pulse extra starts while drawing and during the done cycle
    task automatic run_cmd(input string name, input int cx0, input int cy0,
                           input int cw, input int ch, input int ccol,
                           input bit outl, input int rmode, input bit noise);
        int  exs[$];
        int  eys[$];
        int  xe, ye, idx, limit;
        bit  empty, finished;
        empty = (cw == 0) || (ch == 0) || (cx0 >= WIDTH) || (cy0 >= HEIGHT);
        if (!empty) begin
            xe = (cx0 + cw - 1 > WIDTH - 1)  ? WIDTH - 1  : cx0 + cw - 1;
            ye = (cy0 + ch - 1 > HEIGHT - 1) ? HEIGHT - 1 : cy0 + ch - 1;
            for (int yy = cy0; yy <= ye; yy++)
                for (int xx = cx0; xx <= xe; xx++)
                    if (!outl || yy == cy0 || yy == ye || xx == cx0 || xx == xe) begin
                        exs.push_back(xx);
                        eys.push_back(yy);
                    end
        end
        x0 = 8'(cx0); y0 = 9'(cy0); w = 8'(cw); h = 9'(ch);
        fill_color = 3'(ccol);
`ifdef RECT_OUTLINE_EN
        outline = outl;
`endif
        start = 1'b1;
        pixel_ready = 1'b1;
        idx = 0;
        finished = 1'b0;
        limit = exs.size() * 4 + 8;
        for (int cyc = 1; cyc <= limit && !finished; cyc++) begin
            @(posedge clk50M); #1;
            start = 1'b0;
            scramble_cmd();
            if (idx < exs.size()) begin
                n_cmp++;
                if (write_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s ctrl pix%0d: we=%b busy=%b done=%b required 1/1/0",
                             name, idx, write_en, busy, done);
                end
                n_cmp++;
                if (x !== 8'(exs[idx]) || y !== 9'(eys[idx]) || color !== 3'(ccol)) begin
                    n_err++;
                    $display("FAIL %s pixel%0d: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                             name, idx, x, y, color, exs[idx], eys[idx], ccol);
                end
                if (noise && cyc == 2) start = 1'b1;
                case (rmode)
                    0:       pixel_ready = 1'b1;
                    1:       pixel_ready = (cyc % 2) == 0;
                    default: pixel_ready = ($urandom_range(0, 3) != 0);
                endcase
                if (pixel_ready) idx++;
            end else begin
                n_cmp++;
                if (done !== 1'b1 || busy !== 1'b0 || write_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s done cycle %0d: done=%b busy=%b we=%b required 1/0/0",
                             name, cyc, done, busy, write_en);
                end
                finished = 1'b1;
                if (noise) start = 1'b1;
            end
        end
        if (!finished) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: %0d of %0d pixels, done never seen",
                     name, idx, exs.size());
        end
        @(posedge clk50M); #1;
        start = 1'b0;
        check_idle({name, " after"});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk50M);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || write_en !== 1'b0 ||
            x !== 8'd0 || y !== 9'd0 || color !== 3'd0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b we=%b x=%0d y=%0d c=%0d required all 0",
                     busy, done, write_en, x, y, color);
        end
        rst = 1'b0;
        @(posedge clk50M); #1;
        check_idle("reset_release");
    endtask

    task automatic test_solid_fill();
        run_cmd("solid", 10, 20, 3, 2, 4, 1'b0, 0, 1'b0);
    endtask

    task automatic test_clipping();
        run_cmd("clip_corner", 238, 318, 5, 5, 7, 1'b0, 0, 1'b0);
        run_cmd("clip_right", 235, 0, 100, 1, 2, 1'b0, 0, 1'b0);
    endtask

    task automatic test_empty();
        run_cmd("empty_w0", 5, 5, 0, 4, 1, 1'b0, 0, 1'b0);
        run_cmd("empty_h0", 5, 5, 4, 0, 1, 1'b0, 0, 1'b0);
        run_cmd("empty_x240", 240, 5, 4, 4, 1, 1'b0, 0, 1'b0);
        run_cmd("empty_y320", 5, 320, 4, 4, 1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_cmd("bp_alt", 50, 60, 2, 2, 3, 1'b0, 1, 1'b0);
        run_cmd("bp_rand", 100, 100, 5, 4, 6, 1'b0, 2, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_cmd("ign_start", 20, 30, 4, 4, 5, 1'b0, 0, 1'b1);
        run_cmd("ign_start_bp", 0, 0, 3, 3, 2, 1'b0, 2, 1'b1);
    endtask

    task automatic test_reset_mid_draw();
        x0 = 8'd5; y0 = 9'd5; w = 8'd4; h = 9'd4; fill_color = 3'd5;
`ifdef RECT_OUTLINE_EN
        outline = 1'b0;
`endif
        pixel_ready = 1'b1;
        start = 1'b1;
        repeat (3) begin
            @(posedge clk50M); #1;
            start = 1'b0;
        end
        n_cmp++;
        if (write_en !== 1'b1 || x !== 8'd7 || y !== 9'd5) begin
            n_err++;
            $display("FAIL rst_mid third pixel: we=%b (%0d,%0d) required 1 (7,5)",
                     write_en, x, y);
        end
        rst = 1'b1;
        @(posedge clk50M); #1;
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || write_en !== 1'b0 ||
            x !== 8'd0 || y !== 9'd0 || color !== 3'd0) begin
            n_err++;
            $display("FAIL rst_mid: busy=%b done=%b we=%b x=%0d y=%0d c=%0d required all 0",
                     busy, done, write_en, x, y, color);
        end
        repeat (2) begin
            @(posedge clk50M); #1;
            check_idle("rst_mid_after");
        end
        run_cmd("rst_mid_recover", 1, 2, 2, 2, 6, 1'b0, 0, 1'b0);
    endtask

    task automatic test_outline();
`ifdef RECT_OUTLINE_EN
        run_cmd("outline_4x3", 0, 0, 4, 3, 7, 1'b1, 0, 1'b0);
        run_cmd("outline_1col", 30, 40, 1, 4, 3, 1'b1, 0, 1'b0);
        run_cmd("outline_clip", 236, 310, 9, 20, 1, 1'b1, 2, 1'b0);
`endif
    endtask

    task automatic test_random();
        int cx0, cy0, cw, ch;
        bit outl;
        for (int i = 0; i < 40; i++) begin
            cx0 = ($urandom_range(0, 1) != 0) ? $urandom_range(225, 255) : $urandom_range(0, 255);
            cy0 = ($urandom_range(0, 1) != 0) ? $urandom_range(305, 340) : $urandom_range(0, 511);
            cw  = $urandom_range(0, 12);
            ch  = $urandom_range(0, 8);
`ifdef RECT_OUTLINE_EN
            outl = 1'($urandom);
`else
            outl = 1'b0;
`endif
            run_cmd("random", cx0, cy0, cw, ch, $urandom_range(0, 7), outl,
                    $urandom_range(0, 2), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_solid_fill();
        test_clipping();
        test_empty();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_draw();
        test_outline();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
